// File: rtl/nes_joypad_pkg.sv
// Package nes_ctrl_pkg: shared definitions for the NES joypad emulation.
//   - BTN_* : bit positions of each button inside a controller report byte.
//   - btn_t : one controller report, 1 = pressed.
//   - dpad_filter() : cancels physically impossible opposing D-pad pairs.
package nes_ctrl_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] btn_t;

  // Up+Down reads as neither, Left+Right reads as neither; other bits pass.
  function automatic btn_t dpad_filter(input btn_t b);
    btn_t r;
    r = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      r[BTN_UP]   = 1'b0;
      r[BTN_DOWN] = 1'b0;
    end else begin
      r[BTN_UP]   = b[BTN_UP];
      r[BTN_DOWN] = b[BTN_DOWN];
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      r[BTN_LEFT]  = 1'b0;
      r[BTN_RIGHT] = 1'b0;
    end else begin
      r[BTN_LEFT]  = b[BTN_LEFT];
      r[BTN_RIGHT] = b[BTN_RIGHT];
    end
    return r;
  endfunction

endpackage

// File: rtl/nes_joypad_port.sv
// nes_joypad_port: one 4021-style controller shift register.
//   clk, rst_n      : clk_cpu and async active-low reset.
//   btn_i           : synchronised button byte (btn_t layout).
//   turbo_a_i/_b_i  : synchronised turbo enables for A and B.
//   turbo_phase_i   : shared turbo square wave from the top.
//   latch_i         : console latch; reloads continuously while high.
//   strobe_i        : read-clock pulse for this port.
//   data_o          : registered serial bit (sr[0]), 1 = pressed.
module nes_joypad_port
  import nes_ctrl_pkg::*;
#(
  parameter bit DPAD_FILTER = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  btn_t btn_i,
  input  logic turbo_a_i,
  input  logic turbo_b_i,
  input  logic turbo_phase_i,
  input  logic latch_i,
  input  logic strobe_i,
  output logic data_o
);

  btn_t turbo_btn_s;
  btn_t eff_btn_s;
  btn_t sr_d;
  btn_t sr_q;

  // Effective report: turbo OR on A/B, then optional opposing-direction filter.
  always_comb begin
    turbo_btn_s         = btn_i;
    turbo_btn_s[BTN_A]  = btn_i[BTN_A] | (turbo_a_i & turbo_phase_i);
    turbo_btn_s[BTN_B]  = btn_i[BTN_B] | (turbo_b_i & turbo_phase_i);
    if (DPAD_FILTER) begin
      eff_btn_s = dpad_filter(turbo_btn_s);
    end else begin
      eff_btn_s = turbo_btn_s;
    end
  end

  // Next shift-register value: latch beats strobe; ones fill in from the top.
  always_comb begin
    if (latch_i) begin
      sr_d = eff_btn_s;
    end else if (strobe_i) begin
      sr_d = {1'b1, sr_q[7:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= 8'h00;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_o = sr_q[0];

endmodule

// File: rtl/nes_joypad.sv
// nes_joypad: two emulated NES controllers on the console side.
//   clk, rst_n       : clk_cpu and async active-low reset.
//   ctrl_out[0]      : latch from the console (bit 1 ignored).
//   ctrl_strobe[1:0] : per-port read-clock pulses (bit 2 ignored).
//   ctrl_data[1:0]   : registered serial data per port, 1 = pressed.
//   btn0, btn1       : async button bytes, active-high.
//   turbo_a, turbo_b : async per-port turbo enables.
// Holds the input synchronisers, latch edge detector and turbo counter;
// the per-port datapath lives in nes_joypad_port.
module nes_joypad
  import nes_ctrl_pkg::*;
#(
  parameter int TURBO_PERIOD = 2,
  parameter bit DPAD_FILTER  = 1'b1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ctrl_out,
  input  logic [2:0] ctrl_strobe,
  output logic [1:0] ctrl_data,
  input  logic [7:0] btn0,
  input  logic [7:0] btn1,
  input  logic [1:0] turbo_a,
  input  logic [1:0] turbo_b
);

  localparam int SW  = 20;
  localparam int TCW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
  localparam logic [TCW-1:0] TCNT_MAX = TCW'(TURBO_PERIOD - 1);

  logic [SW-1:0]  raw_s;
  logic [SW-1:0]  sync_q [SYNC_STAGES];
  logic [SW-1:0]  synced_s;
  logic           latch_s;
  logic           latch_q;
  logic           latch_rise_s;
  logic [TCW-1:0] tcnt_d;
  logic [TCW-1:0] tcnt_q;
  logic           phase_d;
  logic           phase_q;
  logic           unused_s;

  assign raw_s    = {turbo_b, turbo_a, btn1, btn0};
  assign synced_s = sync_q[SYNC_STAGES-1];
  assign unused_s = ctrl_out[1] ^ ctrl_strobe[2];

  // Multi-flop synchroniser chain for all asynchronous board inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {SW{1'b0}};
      end
    end else begin
      sync_q[0] <= raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // The latch comes from the console in clk_cpu, so it is used directly.
  assign latch_s      = ctrl_out[0];
  assign latch_rise_s = latch_s & ~latch_q;

  // Turbo counter: one count per latch rising edge, phase flips on wrap.
  always_comb begin
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    if (latch_rise_s) begin
      if (tcnt_q == TCNT_MAX) begin
        tcnt_d  = {TCW{1'b0}};
        phase_d = ~phase_q;
      end else begin
        tcnt_d  = tcnt_q + TCW'(1'b1);
        phase_d = phase_q;
      end
    end else begin
      tcnt_d  = tcnt_q;
      phase_d = phase_q;
    end
  end

  // Latch edge detector and turbo state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= 1'b0;
      tcnt_q  <= {TCW{1'b0}};
      phase_q <= 1'b0;
    end else begin
      latch_q <= latch_s;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  end

  nes_joypad_port #(
    .DPAD_FILTER (DPAD_FILTER)
  ) u_port0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_i         (synced_s[7:0]),
    .turbo_a_i     (synced_s[16]),
    .turbo_b_i     (synced_s[18]),
    .turbo_phase_i (phase_q),
    .latch_i       (latch_s),
    .strobe_i      (ctrl_strobe[0]),
    .data_o        (ctrl_data[0])
  );

  nes_joypad_port #(
    .DPAD_FILTER (DPAD_FILTER)
  ) u_port1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_i         (synced_s[15:8]),
    .turbo_a_i     (synced_s[17]),
    .turbo_b_i     (synced_s[19]),
    .turbo_phase_i (phase_q),
    .latch_i       (latch_s),
    .strobe_i      (ctrl_strobe[1]),
    .data_o        (ctrl_data[1])
  );

endmodule

// File: tb/tb_nes_joypad.sv
module tb_nes_joypad;

  localparam int TP0 = 2;
  localparam int TP1 = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] ctrl_out;
  logic [2:0] ctrl_strobe;
  logic [1:0] data_a;
  logic [1:0] data_b;
  logic [7:0] btn0;
  logic [7:0] btn1;
  logic [1:0] turbo_a;
  logic [1:0] turbo_b;

  int n_checks;
  int n_fail;
  int edges;

  // dut_a: default parameters; dut_b: filter off, slower turbo, deeper sync.
  nes_joypad #(.TURBO_PERIOD(TP0), .DPAD_FILTER(1'b1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctrl_out(ctrl_out), .ctrl_strobe(ctrl_strobe),
    .ctrl_data(data_a), .btn0(btn0), .btn1(btn1), .turbo_a(turbo_a), .turbo_b(turbo_b)
  );

  nes_joypad #(.TURBO_PERIOD(TP1), .DPAD_FILTER(1'b0), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctrl_out(ctrl_out), .ctrl_strobe(ctrl_strobe),
    .ctrl_data(data_b), .btn0(btn0), .btn1(btn1), .turbo_a(turbo_a), .turbo_b(turbo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference report: what a controller presents after turbo and filtering.
  function automatic logic [7:0] model(input logic [7:0] b, input logic ta, input logic tb,
                                       input logic phase, input logic filt);
    logic [7:0] e;
    e = b;
    if (ta && phase) e[0] = 1'b1;
    if (tb && phase) e[1] = 1'b1;
    if (filt && e[4] && e[5]) begin e[4] = 1'b0; e[5] = 1'b0; end
    if (filt && e[6] && e[7]) begin e[6] = 1'b0; e[7] = 1'b0; end
    return e;
  endfunction

  // Turbo phase in force when the latch edge with 1-based number e loads.
  function automatic logic phase_at(input int e, input int tp);
    return ((e - 1) / tp) % 2 == 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_latch();
    @(negedge clk);
    ctrl_out = 2'b01;
    @(posedge clk);
    #1;
    ctrl_out = 2'b00;
    edges++;
  endtask

  // One read cycle: strobe high for one posedge, sample during the strobe.
  task automatic do_read(input logic [2:0] s, output logic [1:0] sa, output logic [1:0] sb);
    @(negedge clk);
    ctrl_strobe = s;
    #1;
    sa = data_a;
    sb = data_b;
    @(posedge clk);
    #1;
    ctrl_strobe = 3'b000;
  endtask

  typedef struct {
    logic [7:0] btn;
    logic [7:0] exp_filt;
    logic [7:0] exp_raw;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [1:0] sa, sb;
    logic [7:0] ga0, ga1, gb0, gb1;
    logic [7:0] ea [2];
    logic [7:0] eb [2];
    int k [2];
    n_checks = 0;
    n_fail   = 0;
    edges    = 0;

    vecs[0] = '{8'h09, 8'h09, 8'h09};
    vecs[1] = '{8'h30, 8'h00, 8'h30};
    vecs[2] = '{8'h50, 8'h50, 8'h50};
    vecs[3] = '{8'hC0, 8'h00, 8'hC0};
    vecs[4] = '{8'hF0, 8'h00, 8'hF0};
    vecs[5] = '{8'h3C, 8'h0C, 8'h3C};
    vecs[6] = '{8'hFF, 8'h0F, 8'hFF};
    vecs[7] = '{8'hA5, 8'hA5, 8'hA5};

    rst_n = 1'b0; ctrl_out = 2'b00; ctrl_strobe = 3'b000;
    btn0 = 8'h00; btn1 = 8'h00; turbo_a = 2'b00; turbo_b = 2'b00;
    #1;
    check("reset_data_a", {30'd0, data_a}, 32'd0);
    check("reset_data_b", {30'd0, data_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic read: A+Start, 10 reads on port 0, port 1 untouched.
    btn0 = 8'h09;
    settle();
    pulse_latch();
    for (int i = 0; i < 10; i++) begin
      do_read(3'b001, sa, sb);
      check($sformatf("basic_read%0d", i), {31'd0, sa[0]}, (i < 8) ? {31'd0, ga0[0] | 1'b0} & 32'd0 | {31'd0, (i >= 8) || ((8'h09 >> i) & 8'h01) != 8'h00} : 32'd1);
      check($sformatf("basic_p1_%0d", i), {31'd0, sa[1]}, 32'd0);
    end

    // Table: filter on (dut_a) and off (dut_b), both ports, turbo off.
    for (int v = 0; v < 8; v++) begin
      btn0 = vecs[v].btn;
      btn1 = vecs[v].btn;
      settle();
      pulse_latch();
      for (int i = 0; i < 8; i++) begin
        do_read(3'b011, sa, sb);
        ga0[i] = sa[0]; ga1[i] = sa[1]; gb0[i] = sb[0]; gb1[i] = sb[1];
      end
      check($sformatf("tbl%0d_filt_p0", v), {24'd0, ga0}, {24'd0, vecs[v].exp_filt});
      check($sformatf("tbl%0d_filt_p1", v), {24'd0, ga1}, {24'd0, vecs[v].exp_filt});
      check($sformatf("tbl%0d_raw_p0", v), {24'd0, gb0}, {24'd0, vecs[v].exp_raw});
      check($sformatf("tbl%0d_raw_p1", v), {24'd0, gb1}, {24'd0, vecs[v].exp_raw});
    end

    // Latch held high while strobing port 1: no shifting, A stays visible.
    btn1 = 8'h02;
    settle();
    @(negedge clk);
    ctrl_out = 2'b01;
    edges++;
    for (int i = 0; i < 3; i++) begin
      do_read(3'b010, sa, sb);
      check($sformatf("latch_hold%0d", i), {31'd0, sa[1]}, 32'd0);
    end
    @(negedge clk);
    ctrl_out = 2'b00;
    do_read(3'b010, sa, sb);
    check("after_hold_A", {31'd0, sa[1]}, 32'd0);
    do_read(3'b010, sa, sb);
    check("after_hold_B", {31'd0, sa[1]}, 32'd1);

    // Latch and strobe in the same cycle: reload wins.
    btn0 = 8'hFF;
    settle();
    pulse_latch();
    btn0 = 8'hFE;
    settle();
    @(negedge clk);
    ctrl_out = 2'b01;
    ctrl_strobe = 3'b001;
    @(posedge clk);
    #1;
    ctrl_out = 2'b00;
    ctrl_strobe = 3'b000;
    edges++;
    check("latch_prio", {31'd0, data_a[0]}, 32'd0);

    // Turbo A on port 0 over 8 frames, from a fresh counter.
    do_reset();
    btn0 = 8'h00; btn1 = 8'h00; turbo_a = 2'b01;
    settle();
    for (int f = 0; f < 8; f++) begin
      pulse_latch();
      do_read(3'b011, sa, sb);
      check($sformatf("turbo_a_f%0d", f), {31'd0, sa[0]}, {31'd0, (f % 4) >= 2});
      check($sformatf("turbo_b_f%0d", f), {31'd0, sb[0]}, {31'd0, (f % 6) >= 3});
      check($sformatf("turbo_p1_f%0d", f), {31'd0, sa[1]}, 32'd0);
    end
    turbo_a = 2'b00;

    // Reset mid-read, then a clean reload.
    btn0 = 8'h09;
    settle();
    pulse_latch();
    for (int i = 0; i < 3; i++) do_read(3'b001, sa, sb);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_a", {30'd0, data_a}, 32'd0);
    check("midreset_b", {30'd0, data_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    btn0 = 8'h80;
    settle();
    pulse_latch();
    for (int i = 0; i < 10; i++) begin
      do_read(3'b001, sa, sb);
      check($sformatf("post_reset_read%0d", i), {31'd0, sa[0]}, {31'd0, i >= 7});
    end

    // Randomised frames against the reference model, interleaved port reads.
    do_reset();
    for (int f = 0; f < 30; f++) begin
      btn0 = 8'($urandom); btn1 = 8'($urandom);
      turbo_a = 2'($urandom); turbo_b = 2'($urandom);
      settle();
      pulse_latch();
      ea[0] = model(btn0, turbo_a[0], turbo_b[0], phase_at(edges, TP0), 1'b1);
      ea[1] = model(btn1, turbo_a[1], turbo_b[1], phase_at(edges, TP0), 1'b1);
      eb[0] = model(btn0, turbo_a[0], turbo_b[0], phase_at(edges, TP1), 1'b0);
      eb[1] = model(btn1, turbo_a[1], turbo_b[1], phase_at(edges, TP1), 1'b0);
      k[0] = 0; k[1] = 0;
      for (int r = 0; r < 14; r++) begin
        logic [2:0] s;
        s = 3'($urandom_range(1, 7));
        do_read(s, sa, sb);
        for (int p = 0; p < 2; p++) begin
          if (s[p]) begin
            check($sformatf("rnd_f%0d_a_p%0d_k%0d", f, p, k[p]), {31'd0, sa[p]},
                  {31'd0, (k[p] >= 8) ? 1'b1 : ea[p][k[p]]});
            check($sformatf("rnd_f%0d_b_p%0d_k%0d", f, p, k[p]), {31'd0, sb[p]},
                  {31'd0, (k[p] >= 8) ? 1'b1 : eb[p][k[p]]});
            k[p]++;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
